mastermind_ctrl: RTL
====================

Name: mastermind_ctrl

Overview:
Game controller that sequences a Mastermind round on the DE10 board. It owns the 4-slot code entry (slot pointer, per-slot digit registers), latches the secret, and scores each completed guess with a multi-cycle black/white peg counter. It also tracks turns and declares win or loss. It drives the seven_segment digit inputs (d0..d3) and LED status; upstream key debouncing and synchronisation produce single-cycle pulses into this block.

Parameters:
MAX_TURNS, 10, guesses allowed per game (1..15)
LFSR_SEED, 16'hACE1, LFSR reset value (only used with MM_LFSR_SECRET_EN)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
RESET_N  input  1  asynchronous active-low reset
new_game  input  1  1-cycle pulse; latch secret, start game
enter  input  1  1-cycle pulse; commit guess_digit to current slot
guess_digit  input  3  colour value, from SW[2:0]
secret_in  input  12  secret {slot3,slot2,slot1,slot0}, 3 bits each (used without macro)
d0,d1,d2,d3  output  3 each  current guess digits to seven_segment
slot_sel  output  2  slot the next enter writes
black  output  3  exact matches, last scored guess
white  output  3  colour-only matches, last scored guess
score_valid  output  1  1-cycle pulse when black/white update
turn  output  4  completed guesses this game
busy  output  1  high in CHECK/COUNT/RESULT
won, lost  output  1 each  sticky until new_game/reset

Behaviour:
- Async reset (RESET_N=0): state IDLE; d0..d3=0, slot_sel=0, black=0, white=0, score_valid=0, turn=0, won=0, lost=0, busy=0, secret=0.
- States: IDLE, ENTRY, CHECK, COUNT, RESULT, WON, LOST.
- new_game from any state, highest priority: latch secret, clear d0..d3/slot_sel/black/white/turn/won/lost, go to ENTRY next cycle. new_game and enter in the same cycle: enter is ignored.
- IDLE/WON/LOST: enter ignored.
- ENTRY: on enter, d[slot_sel] <= guess_digit and slot_sel increments. When enter hits slot 3, slot_sel wraps to 0 and state goes to CHECK.
- CHECK (1 cycle): blk = count of slots i with d_i == secret_i; clear accumulator acc=0, colour counter c=0.
- COUNT (8 cycles, c=0..7): acc += min(#secret slots == c, #guess slots == c). Counts 0..4 and acc 0..4 all fit in 3 bits, with no overflow.
- RESULT (1 cycle): black<=blk, white<=acc-blk, score_valid=1, turn<=turn+1. Next state: WON if blk==4; else LOST if turn+1==MAX_TURNS; else ENTRY with d0..d3 cleared to 0.
- Latency: enter on slot 3 at cycle N gives CHECK at N+1, COUNT at N+2..N+9, RESULT/score_valid at N+10. enter during CHECK/COUNT/RESULT is dropped.
- black/white hold their values until the next RESULT or until new_game.
- Reset mid-scoring returns to IDLE with all outputs at their reset values and no score_valid pulse.

Optional Feature:
MM_LFSR_SECRET_EN
- Defined: a free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) resets to LFSR_SEED and steps every clock. new_game latches the secret from lfsr[11:0]. secret_in is unused.
- Undefined: new_game latches the secret from secret_in and no LFSR is built.

Test Plan:
- Without macro: secret_in={4,3,2,1}, new_game, enter 1,2,3,4 -> score_valid exactly 10 cycles after the last enter; black=4, white=0, turn=1, won=1. Further enters are ignored.
- Same secret, guess 4,3,2,1 -> black=0, white=4, turn=1, state ENTRY, d0..d3=0, slot_sel=0.
- secret_in={2,2,1,1}, guess 1,2,1,0 -> black=1, white=2.
- MAX_TURNS=10, ten guesses 0,0,0,0 against secret {4,3,2,1} -> black=0 and white=0 each turn; after the tenth score lost=1 and turn=10. An enter afterwards changes nothing. new_game clears lost and turn.
- Reset in COUNT (cycle N+5) -> all outputs 0 immediately and no score_valid. enter before new_game is ignored; enter in the same cycle as new_game is ignored.
- With macro and LFSR_SEED=16'hACE1: reset, wait K cycles, new_game -> secret equals the reference-model LFSR[11:0] at that cycle. Guessing those digits gives black=4.

Source files
------------

// File: rtl/mastermind_ctrl.sv
// rtl/mastermind_ctrl.sv - Mastermind round controller: code entry, peg scoring, turn/win/loss tracking
// Build option MM_LFSR_SECRET_EN: secret comes from a free-running LFSR instead of secret_in.
module mastermind_ctrl #(
    parameter int          MAX_TURNS = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        new_game,
    input  logic        enter,
    input  logic [2:0]  guess_digit,
    input  logic [11:0] secret_in,
    output logic [2:0]  d0,
    output logic [2:0]  d1,
    output logic [2:0]  d2,
    output logic [2:0]  d3,
    output logic [1:0]  slot_sel,
    output logic [2:0]  black,
    output logic [2:0]  white,
    output logic        score_valid,
    output logic [3:0]  turn,
    output logic        busy,
    output logic        won,
    output logic        lost
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_COUNT,
        S_RESULT,
        S_WON,
        S_LOST
    } state_t;

    state_t state, state_next;

    logic [3:0][2:0] guess_q;
    logic [3:0][2:0] secret_q;
    logic [1:0]      slot_q;
    logic [2:0]      colour_q;
    logic [2:0]      acc_q;
    logic [2:0]      blk_q;
    logic [2:0]      black_q;
    logic [2:0]      white_q;
    logic            score_q;
    logic [3:0]      turn_q;
    logic            won_q;
    logic            lost_q;

    logic [11:0]     secret_src;
    logic [2:0]      exact_cnt;
    logic [2:0]      secret_cnt;
    logic [2:0]      guess_cnt;
    logic [2:0]      min_cnt;
    logic [2:0]      acc_next;
    logic            last_turn;

`ifdef MM_LFSR_SECRET_EN
    logic [15:0] lfsr_q;
    logic        unused_secret_in;

    // Taps 16,14,13,11 in right-shift form: feedback enters at bit 15.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign secret_src       = lfsr_q[11:0];
    assign unused_secret_in = ^secret_in;
`else
    logic unused_seed;

    assign secret_src  = secret_in;
    assign unused_seed = ^LFSR_SEED;
`endif

    function automatic logic [2:0] count_colour(input logic [3:0][2:0] v, input logic [2:0] col);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] == col) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

    always_comb begin
        exact_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            if (guess_q[i] == secret_q[i]) begin
                exact_cnt = exact_cnt + 3'd1;
            end
        end
    end

    // One colour per COUNT cycle; the per-colour minimum summed over all colours
    // is the total number of pegs with the right colour regardless of position.
    assign secret_cnt = count_colour(secret_q, colour_q);
    assign guess_cnt  = count_colour(guess_q, colour_q);
    assign min_cnt    = (secret_cnt < guess_cnt) ? secret_cnt : guess_cnt;
    assign acc_next   = acc_q + min_cnt;
    assign last_turn  = (turn_q == 4'(MAX_TURNS));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (new_game) begin
            state_next = S_ENTRY;
        end else begin
            case (state)
                S_ENTRY: begin
                    if (enter && (slot_q == 2'd3)) begin
                        state_next = S_CHECK;
                    end
                end
                S_CHECK: state_next = S_COUNT;
                S_COUNT: begin
                    if (colour_q == 3'd7) begin
                        state_next = S_RESULT;
                    end
                end
                S_RESULT: begin
                    // black_q/turn_q were updated on the way into RESULT.
                    if (black_q == 3'd4) begin
                        state_next = S_WON;
                    end else if (last_turn) begin
                        state_next = S_LOST;
                    end else begin
                        state_next = S_ENTRY;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            guess_q  <= '0;
            secret_q <= '0;
            slot_q   <= '0;
            colour_q <= '0;
            acc_q    <= '0;
            blk_q    <= '0;
            black_q  <= '0;
            white_q  <= '0;
            score_q  <= 1'b0;
            turn_q   <= '0;
            won_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            score_q <= 1'b0;
            if (new_game) begin
                secret_q <= secret_src;
                guess_q  <= '0;
                slot_q   <= '0;
                colour_q <= '0;
                acc_q    <= '0;
                blk_q    <= '0;
                black_q  <= '0;
                white_q  <= '0;
                turn_q   <= '0;
                won_q    <= 1'b0;
                lost_q   <= 1'b0;
            end else begin
                case (state)
                    S_ENTRY: begin
                        if (enter) begin
                            guess_q[slot_q] <= guess_digit;
                            slot_q          <= slot_q + 2'd1;
                        end
                    end
                    S_CHECK: begin
                        blk_q    <= exact_cnt;
                        acc_q    <= '0;
                        colour_q <= '0;
                    end
                    S_COUNT: begin
                        acc_q    <= acc_next;
                        colour_q <= colour_q + 3'd1;
                        // Publish on the final colour so the pulse and the new
                        // pegs are both visible during the RESULT cycle.
                        if (colour_q == 3'd7) begin
                            black_q <= blk_q;
                            white_q <= acc_next - blk_q;
                            score_q <= 1'b1;
                            turn_q  <= turn_q + 4'd1;
                        end
                    end
                    S_RESULT: begin
                        if (black_q == 3'd4) begin
                            won_q <= 1'b1;
                        end else if (last_turn) begin
                            lost_q <= 1'b1;
                        end else begin
                            guess_q <= '0;
                            slot_q  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign d0          = guess_q[0];
    assign d1          = guess_q[1];
    assign d2          = guess_q[2];
    assign d3          = guess_q[3];
    assign slot_sel    = slot_q;
    assign black       = black_q;
    assign white       = white_q;
    assign score_valid = score_q;
    assign turn        = turn_q;
    assign won         = won_q;
    assign lost        = lost_q;
    assign busy        = (state == S_CHECK) || (state == S_COUNT) || (state == S_RESULT);

endmodule
